// File: rtl/dxm_cdc_tx_if.sv
// Source-side bundle of the four-phase req/ack crossing: local valid/ready input
// plus the registered crossing outputs, the async ack, and status flags.
interface dxm_cdc_tx_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              cdc_req;
  logic [DATA_W-1:0] cdc_data;
  logic              cdc_ack;
  logic              done;
  logic              err;

  modport master (
    output in_valid, in_data, cdc_ack,
    input  in_ready, cdc_req, cdc_data, done, err
  );

  modport slave (
    input  in_valid, in_data, cdc_ack,
    output in_ready, cdc_req, cdc_data, done, err
  );
endinterface

// File: rtl/dxm_cdc_tx.sv
// Four-phase CDC transmitter: loads a word, raises cdc_req a cycle later, retires on synced ack.
// in_ready only in IDLE, so a new word waits until the whole req/ack cycle has retired.
module dxm_cdc_tx #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,   // legal range 2..4
  parameter int TIMEOUT     = 255  // 0 disables the watchdog
) (
  input  logic        clk,
  input  logic        rst_n,
  dxm_cdc_tx_if.slave bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, REQ, REL} state_t;

  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] sync;
  logic                   ack_s;
  logic [DATA_W-1:0]      data_q;
  logic                   load;
  logic                   req_q, req_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt, cnt_d;

  assign ack_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], bus.cdc_ack};
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    req_d   = req_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt;
    case (state)
      IDLE:  if (bus.in_valid) begin
               load    = 1'b1;
               state_d = SETUP;
             end
      SETUP: begin
               req_d   = 1'b1;
               state_d = REQ;
             end
      REQ:   if (ack_s) begin
               req_d   = 1'b0;
               state_d = REL;
             end
      REL:   if (!ack_s) begin
               done_d  = 1'b1;
               state_d = IDLE;
             end
      default: state_d = IDLE;
    endcase
    // An ack seen before the request is up means the receiver is out of step.
    if (ack_s && (state == IDLE || state == SETUP)) err_d = 1'b1;
    if (state_d != state) begin
      cnt_d = '0;
    end else if ((state == REQ || state == REL) && cnt != TMO) begin
      cnt_d = cnt + CNT_W'(1);
      if (TIMEOUT != 0 && cnt_d == TMO) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt    <= '0;
      data_q <= '0;
    end else begin
      state  <= state_d;
      req_q  <= req_d;
      done_q <= done_d;
      err_q  <= err_d;
      cnt    <= cnt_d;
      if (load) data_q <= bus.in_data;
    end
  end

  assign bus.in_ready = (state == IDLE);
  assign bus.cdc_req  = req_q;
  assign bus.cdc_data = data_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_dxm_cdc_tx.sv
// Directed bench for dxm_cdc_tx (SYNC_STAGES=2, TIMEOUT=10); inputs driven and outputs
// sampled 1 time unit after each rising edge.
module tb_dxm_cdc_tx;

  logic clk;
  logic rst_n;
  logic follow;
  logic ack_man;
  int   tests;
  int   fails;

  dxm_cdc_tx_if #(.DATA_W(32)) bus ();

  // Receiver model: either a hand-driven ack or an instant echo of cdc_req.
  assign bus.cdc_ack = follow ? bus.cdc_req : ack_man;

  dxm_cdc_tx #(.DATA_W(32), .SYNC_STAGES(2), .TIMEOUT(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'($urandom);
      bus.in_data  = $urandom;
      ack_man      = 1'($urandom);
      tick();
    end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    tests++; if (bus.cdc_req !== 1'b0) begin fails++; $display("FAIL rst_cdc_req got=%b exp=0", bus.cdc_req); end
    tests++; if (bus.cdc_data !== 32'h0) begin fails++; $display("FAIL rst_cdc_data got=%h exp=0", bus.cdc_data); end
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    ack_man      = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL post_rst_in_ready got=%b exp=1", bus.in_ready); end
    tests++; if (bus.cdc_req !== 1'b0) begin fails++; $display("FAIL post_rst_cdc_req got=%b exp=0", bus.cdc_req); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL post_rst_done got=%b exp=0", bus.done); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL post_rst_err got=%b exp=0", bus.err); end
  endtask

  task automatic test_single();
    int dn = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hA5A5_1234;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    tests++; if (bus.cdc_data !== 32'hA5A5_1234) begin fails++; $display("FAIL single_load got=%h exp=a5a51234", bus.cdc_data); end
    tests++; if (bus.in_ready !== 1'b0 || bus.cdc_req !== 1'b0) begin fails++; $display("FAIL single_edgeA rdy=%b req=%b exp=0,0", bus.in_ready, bus.cdc_req); end
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 4)  ack_man = 1'b1;
      if (c == 10) ack_man = 1'b0;
      if (bus.done === 1'b1) dn++;
      tests++; if (bus.cdc_req !== (c <= 6)) begin fails++; $display("FAIL single_req c=%0d got=%b exp=%b", c, bus.cdc_req, (c <= 6)); end
      tests++; if (bus.done !== (c == 13)) begin fails++; $display("FAIL single_done c=%0d got=%b exp=%b", c, bus.done, (c == 13)); end
      tests++; if (bus.in_ready !== (c >= 13)) begin fails++; $display("FAIL single_ready c=%0d got=%b exp=%b", c, bus.in_ready, (c >= 13)); end
      tests++; if (bus.cdc_data !== 32'hA5A5_1234) begin fails++; $display("FAIL single_data c=%0d got=%h exp=a5a51234", c, bus.cdc_data); end
      tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL single_err c=%0d got=%b exp=0", c, bus.err); end
    end
    tests++; if (dn != 1) begin fails++; $display("FAIL single_done_count got=%0d exp=1", dn); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    int          acc_cyc [3];
    int          idx = 0;
    int          dn  = 0;
    w[0] = 32'h1; w[1] = 32'h2; w[2] = 32'h3;
    follow       = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = w[0];
    for (int c = 1; c <= 40; c++) begin
      logic acc;
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (bus.done === 1'b1) dn++;
      if (acc) begin
        acc_cyc[idx] = c;
        tests++; if (bus.cdc_data !== w[idx]) begin fails++; $display("FAIL b2b_word idx=%0d got=%h exp=%h", idx, bus.cdc_data, w[idx]); end
        idx++;
        if (idx < 3) bus.in_data = w[idx];
        else begin
          bus.in_valid = 1'b0;
          bus.in_data  = 32'h0;
        end
      end
    end
    tests++; if (idx != 3) begin fails++; $display("FAIL b2b_accepts got=%0d exp=3", idx); end
    for (int i = 1; i < 3; i++) begin
      if (i < idx) begin
        tests++; if (acc_cyc[i] - acc_cyc[i-1] != 8) begin fails++; $display("FAIL b2b_spacing i=%0d got=%0d exp=8", i, acc_cyc[i] - acc_cyc[i-1]); end
      end
    end
    tests++; if (dn != 3) begin fails++; $display("FAIL b2b_done_count got=%0d exp=3", dn); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL b2b_err got=%b exp=0", bus.err); end
    follow = 1'b0;
  endtask

  task automatic test_timeout();
    int wt = 0;
    int dn = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h55;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      tests++; if (bus.cdc_req !== 1'b1) begin fails++; $display("FAIL tmo_req c=%0d got=%b exp=1", c, bus.cdc_req); end
      tests++; if (bus.err !== (c >= 11)) begin fails++; $display("FAIL tmo_err c=%0d got=%b exp=%b", c, bus.err, (c >= 11)); end
    end
    ack_man = 1'b1;
    while (bus.cdc_req === 1'b1 && wt < 10) begin
      tick();
      wt++;
    end
    tests++; if (bus.cdc_req !== 1'b0) begin fails++; $display("FAIL tmo_req_fall got=%b exp=0", bus.cdc_req); end
    ack_man = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.done === 1'b1) dn++;
    end
    tests++; if (dn != 1) begin fails++; $display("FAIL tmo_done_count got=%0d exp=1", dn); end
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL tmo_err_sticky got=%b exp=1", bus.err); end
    tests++; if (bus.cdc_data !== 32'h55) begin fails++; $display("FAIL tmo_data got=%h exp=55", bus.cdc_data); end
  endtask

  task automatic test_reset_mid_req();
    int dn = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h77;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tests++; if (bus.cdc_req !== 1'b1) begin fails++; $display("FAIL mid_pre_req got=%b exp=1", bus.cdc_req); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.cdc_req !== 1'b0) begin fails++; $display("FAIL mid_req_drop got=%b exp=0", bus.cdc_req); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL mid_in_ready got=%b exp=1", bus.in_ready); end
    tests++; if (bus.cdc_data !== 32'h0) begin fails++; $display("FAIL mid_data got=%h exp=0", bus.cdc_data); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL mid_err got=%b exp=0", bus.err); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    follow       = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.done === 1'b1) dn++;
    end
    tests++; if (dn != 1) begin fails++; $display("FAIL mid_fresh_done got=%0d exp=1", dn); end
    tests++; if (bus.cdc_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL mid_fresh_data got=%h exp=deadbeef", bus.cdc_data); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL mid_fresh_err got=%b exp=0", bus.err); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL mid_fresh_ready got=%b exp=1", bus.in_ready); end
    follow = 1'b0;
  endtask

  task automatic test_spurious_ack();
    int dn = 0;
    ack_man = 1'b1;
    tick();
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL spur_err_e1 got=%b exp=0", bus.err); end
    tick();
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL spur_err_e2 got=%b exp=0", bus.err); end
    tick();
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL spur_err_e3 got=%b exp=1", bus.err); end
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h3C;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    tests++; if (bus.cdc_data !== 32'h3C) begin fails++; $display("FAIL spur_load got=%h exp=3c", bus.cdc_data); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL spur_ready got=%b exp=0", bus.in_ready); end
    tick();
    tests++; if (bus.cdc_req !== 1'b1) begin fails++; $display("FAIL spur_req_rise got=%b exp=1", bus.cdc_req); end
    tick();
    tests++; if (bus.cdc_req !== 1'b0) begin fails++; $display("FAIL spur_req_fall got=%b exp=0", bus.cdc_req); end
    ack_man = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.done === 1'b1) dn++;
    end
    tests++; if (dn != 1) begin fails++; $display("FAIL spur_done got=%0d exp=1", dn); end
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL spur_err_sticky got=%b exp=1", bus.err); end
    tests++; if (bus.cdc_data !== 32'h3C) begin fails++; $display("FAIL spur_data_hold got=%h exp=3c", bus.cdc_data); end
  endtask

  initial begin
    clk          = 1'b0;
    rst_n        = 1'b0;
    follow       = 1'b0;
    ack_man      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    tests        = 0;
    fails        = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_reset_mid_req();
    test_spurious_ack();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
